// File: rtl/binomial_pkg.sv
//------------------------------------------------------------------------------
// binomial_pkg : sample/frame types shared by the loader and binomial_transform.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package binomial_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int N_SAMPLES = 10;
    localparam int IDX_W     = $clog2(N_SAMPLES + 1);

    typedef logic [SAMPLE_W-1:0]           sample_t;
    typedef logic [SAMPLE_W*N_SAMPLES-1:0] frame_t;
    typedef logic [IDX_W-1:0]              idx_t;

endpackage

`default_nettype wire

// File: rtl/loader_bank.sv
//------------------------------------------------------------------------------
// loader_bank : one N_SAMPLES x SAMPLE_W frame buffer with a packed read port.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module loader_bank
    import binomial_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    we,
    input  idx_t    widx,
    input  sample_t wdata,
    output frame_t  rdata
);

    sample_t mem_q [N_SAMPLES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SAMPLES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    for (genvar j = 0; j < N_SAMPLES; j++) begin : g_pack
        assign rdata[SAMPLE_W*j +: SAMPLE_W] = mem_q[j];
    end

endmodule

`default_nettype wire

// File: rtl/binomial_sample_loader.sv
//------------------------------------------------------------------------------
// binomial_sample_loader : ping-pong frame assembler feeding binomial_transform.
// Optional LOADER_FRAME_CNT_EN adds a 16-bit delivered-frame counter port.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module binomial_sample_loader
    import binomial_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    input  logic    in_valid,
    output logic    in_ready,
    input  sample_t in_data,
    output logic    out_valid,
    input  logic    out_ready,
    output frame_t  out_frame,
    output idx_t    fill_level
`ifdef LOADER_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    idx_t       idx_q, idx_d;

    logic       w_accept;
    logic       w_drain;
    logic       w_last;
    logic [1:0] w_bank_we;
    frame_t     w_bank_rd [2];

    always_comb begin
        in_ready  = !full_q[wr_bank_q] && !flush;
        out_valid = full_q[rd_bank_q];
        w_accept  = in_valid && in_ready;
        w_drain   = out_valid && out_ready;
        w_last    = (idx_q == idx_t'(N_SAMPLES - 1));
    end

    // An accept needs a free write bank and a drain needs a full read bank,
    // so when both fire in one cycle they always touch different banks.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        idx_d     = idx_q;

        if (w_drain) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end

        if (flush) begin
            idx_d = '0;
        end else if (w_accept) begin
            if (w_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                idx_d             = '0;
            end else begin
                idx_d = idx_q + idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            idx_q     <= idx_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_bank_we[b] = w_accept && (wr_bank_q == 1'(b));

        loader_bank u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (w_bank_we[b]),
            .widx  (idx_q),
            .wdata (in_data),
            .rdata (w_bank_rd[b])
        );
    end

    assign out_frame  = w_bank_rd[rd_bank_q];
    assign fill_level = idx_q;

`ifdef LOADER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (w_drain) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_binomial_sample_loader.sv
//------------------------------------------------------------------------------
// tb_binomial_sample_loader : scoreboard bench for binomial_sample_loader.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_binomial_sample_loader;
    import binomial_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [159:0] out_frame;
    logic [3:0]  fill_level;
`ifdef LOADER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    always #5 clk = ~clk;

    binomial_sample_loader dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_frame  (out_frame),
        .fill_level (fill_level)
`ifdef LOADER_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    // Reference model: completed frames awaiting drain, and the partial frame.
    logic [159:0] exp_q [$];
    logic [15:0]  partial [$];
    int total   = 0;
    int bad     = 0;
    int stalls  = 0;
    int drained = 0;
    int rmode   = 0;   // 0 never ready, 1 always, 2 random, 3 one-cycle pulse

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // One input-side clock cycle; the model advances after the edge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic f, output logic acc);
        logic [159:0] fr;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        flush    = f;
        #1;
        chk("in_ready", longint'(in_ready), longint'((exp_q.size() < 2) && !f));
        chk("fill_level", longint'(fill_level), longint'(partial.size()));
        acc = v && in_ready;
        @(posedge clk);
        #1;
        if (f) begin
            partial.delete();
        end else if (acc) begin
            partial.push_back(d);
            if (partial.size() == N_SAMPLES) begin
                fr = '0;
                for (int j = 0; j < N_SAMPLES; j++) fr[16*j +: 16] = partial[j];
                exp_q.push_back(fr);
                partial.delete();
            end
        end
    endtask

    task automatic send(input logic [15:0] d);
        logic a;
        int   n = 0;
        do begin
            cycle(1'b1, d, 1'b0, a);
            n++;
            if (!a) stalls++;
        end while (!a && n < 64);
        if (!a) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int k = 0; k < n; k++) cycle(1'b0, 16'h0, 1'b0, a);
    endtask

    task automatic wait_empty();
        logic a;
        int   n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cycle(1'b0, 16'h0, 1'b0, a);
            n++;
        end
        chk("drain_timeout", longint'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        partial.delete();
        drained = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_fill_level", longint'(fill_level), 0);
        total++;
        if (out_frame != '0) begin
            bad++;
            $display("FAIL rst_out_frame actual=%h required=0", out_frame);
        end
    endtask

    // Consumer side: drives out_ready and checks each presented frame.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rmode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                2:       out_ready = ($urandom_range(0, 1) == 1);
                default: begin out_ready = 1'b1; rmode = 0; end
            endcase
            #2;
            chk("out_valid", longint'(out_valid), longint'(exp_q.size() > 0));
            if (out_valid && exp_q.size() > 0) begin
                total++;
                if (out_frame !== exp_q[0]) begin
                    bad++;
                    $display("FAIL out_frame actual=%h required=%h", out_frame, exp_q[0]);
                end
                if (out_ready && !rst) begin
                    void'(exp_q.pop_front());
                    drained++;
                end
            end
        end
    end

    initial begin
        logic a;
        logic v, f;
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        do_reset();

        // Fill B0 with 1..10 while the consumer stalls.
        rmode = 0;
        for (int i = 1; i <= 10; i++) send(16'(i));
        idle(2);

        // Fill B1; further samples must be refused while both banks are full.
        for (int i = 11; i <= 20; i++) send(16'(i));
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 16'(21 + k), 1'b0, a);
            chk("both_full_accept", longint'(a), 0);
        end
        rmode = 3;
        idle(3);
        rmode = 1;
        wait_empty();

        // Continuous streaming with an always-ready consumer.
        stalls = 0;
        for (int i = 1; i <= 30; i++) send(16'(100 + i));
        chk("stream_stalls", longint'(stalls), 0);
        wait_empty();

        // Flush a partial frame, including a sample offered in the flush cycle.
        rmode = 0;
        for (int i = 0; i < 4; i++) send(16'($urandom));
        cycle(1'b1, 16'hDEAD, 1'b1, a);
        chk("flush_accept", longint'(a), 0);
        for (int i = 1; i <= 10; i++) send(16'(i));
        rmode = 1;
        wait_empty();

        // Reset with one full bank and a half-filled bank: nothing survives.
        rmode = 0;
        for (int i = 0; i < 15; i++) send(16'($urandom));
        do_reset();
        rmode = 1;
        idle(5);

        // Random traffic, random backpressure, occasional flush.
        rmode = 2;
        repeat (400) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 24) == 0);
            cycle(v, 16'($urandom), f, a);
        end
        rmode = 1;
        wait_empty();

`ifdef LOADER_FRAME_CNT_EN
        chk("frame_cnt", longint'(frame_cnt), longint'(drained & 16'hFFFF));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
